// File: rtl/ex_mem_unloader.sv
// Data memory unloader: streams a window of two-word beats out on valid/ready.
// Owns the memory read port while busy; a 2-entry skid FIFO absorbs stalls.
module ex_mem_unloader #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int ADDR_STRIDE = 8,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data1,
    input  logic [DATA_W-1:0] mem_rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } stateT;

    stateT stateQ, stateD;

    logic [ADDR_W-1:0] curQ, curD;
    logic [ADDR_W-1:0] endQ, endD;
    logic [ADDR_W-1:0] startAl, endAl;
    logic [ADDR_W-1:0] inflightAddr;
    logic              inflight;
    logic              doneQ, doneD;
    logic              errQ, errD;

    logic [ADDR_W-1:0] fifoAddr  [2];
    logic [DATA_W-1:0] fifoData1 [2];
    logic [DATA_W-1:0] fifoData2 [2];
    logic              fifoLast  [2];
    logic              wrPtr, rdPtr;
    logic [1:0]        count;

    logic       hasBeat, pop, push, issue, flush;
    logic [2:0] pending;

    assign startAl = start_addr & ~ADDR_W'(7);
    assign endAl   = end_addr & ~ADDR_W'(7);

    assign flush   = abort && (stateQ != IDLE);
    assign hasBeat = count != 2'd0;
    assign pop     = hasBeat & out_ready;
    assign push    = inflight & ~flush;

    // Credit check: beats held plus the one in flight, minus the one leaving.
    assign pending = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue   = (stateQ == READ) && !abort
                     && (pending < 3'(FIFO_DEPTH));

    always_comb begin
        stateD = stateQ;
        curD   = curQ;
        endD   = endQ;
        doneD  = 1'b0;
        errD   = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (start) begin
                    if (startAl <= endAl) begin
                        curD   = startAl;
                        endD   = endAl;
                        stateD = READ;
                    end else begin
                        doneD = 1'b1;
                        errD  = 1'b1;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    stateD = IDLE;
                end else if (issue) begin
                    curD = curQ + ADDR_W'(ADDR_STRIDE);
                    if (curQ == endQ) begin
                        stateD = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    stateD = IDLE;
                end else if (!inflight && (count == 2'(pop))) begin
                    doneD  = 1'b1;
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            curQ   <= '0;
            endQ   <= '0;
            doneQ  <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            curQ   <= curD;
            endQ   <= endD;
            doneQ  <= doneD;
            errQ   <= errD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight     <= 1'b0;
            inflightAddr <= '0;
            wrPtr        <= 1'b0;
            rdPtr        <= 1'b0;
            count        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifoAddr[i]  <= '0;
                fifoData1[i] <= '0;
                fifoData2[i] <= '0;
                fifoLast[i]  <= 1'b0;
            end
        end else if (flush) begin
            inflight <= 1'b0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight     <= issue;
            inflightAddr <= curQ;
            if (push) begin
                fifoAddr[wrPtr]  <= inflightAddr;
                fifoData1[wrPtr] <= mem_rd_data1;
                fifoData2[wrPtr] <= mem_rd_data2;
                fifoLast[wrPtr]  <= inflightAddr == endQ;
                wrPtr            <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? curQ : '0;
    assign out_valid   = hasBeat;
    assign out_addr    = hasBeat ? fifoAddr[rdPtr] : '0;
    assign out_data1   = hasBeat ? fifoData1[rdPtr] : '0;
    assign out_data2   = hasBeat ? fifoData2[rdPtr] : '0;
    assign out_last    = hasBeat & fifoLast[rdPtr];
    assign busy        = stateQ != IDLE;
    assign done        = doneQ;
    assign err         = errQ;

endmodule
